// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding,
// line levels and a frame-length helper for benches.
package fifo_uart_pkg;

    // Transmitter FSM states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    // Serial line levels
    localparam logic TX_IDLE  = 1'b1;
    localparam logic TX_START = 1'b0;

    // Enabled clock cycles occupied by one frame (start + data + stop bits)
    function automatic int unsigned frame_cycles(input int unsigned data_width,
                                                 input int unsigned clks_per_bit,
                                                 input int unsigned stop_bits);
        return (32'd1 + data_width + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period timer: counts enabled cycles and raises bit_tick_o on the last
// cycle of each period. The period is CLKS_PER_BIT, or STOP_BITS*CLKS_PER_BIT
// when long_i is set so the whole stop interval is a single period.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_enable,
    input  logic load_i,
    input  logic cnt_en_i,
    input  logic long_i,
    output logic bit_tick_o
);

    localparam int N_LONG = CLKS_PER_BIT * STOP_BITS;
    localparam int CW     = (N_LONG > 1) ? $clog2(N_LONG) : 1;
    localparam logic [CW-1:0] TC_SHORT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] TC_LONG  = CW'(N_LONG - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] tc_s;

    // Terminal-count detect and next count (wraps to zero on the tick)
    always_comb begin
        tc_s       = long_i ? TC_LONG : TC_SHORT;
        bit_tick_o = clk_enable & cnt_en_i & (cnt_q == tc_s);
        cnt_d      = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (cnt_en_i) begin
            if (cnt_q == tc_s) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register, frozen on disabled cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clk_enable) begin
            cnt_q <= cnt_d;
        end else begin
            cnt_q <= cnt_q;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a FIFO read port: pops one word per frame and
// shifts it out LSB-first between a start bit and STOP_BITS stop bits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH        = 8,
    parameter int CLKS_PER_BIT      = 16,
    parameter int FIFO_READ_LATENCY = 1,
    parameter int STOP_BITS         = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_read,
    input  logic [DATA_WIDTH-1:0] fifo_read_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  tx_q, tx_d;
    logic                  fifo_read_q, fifo_read_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;
    logic                  rd_dly_q;
    logic                  load_s;
    logic                  tick_s;
    logic                  tmr_load_s;
    logic                  tmr_en_s;
    logic                  tmr_long_s;

    // Read data is valid during the pulse (latency 0) or the enabled cycle
    // after it (latency 1); the latter coincides with the first START cycle,
    // where tx is forced low anyway, so no extra fetch cycle is needed.
    assign load_s = (FIFO_READ_LATENCY == 0) ? fifo_read_q : rd_dly_q;

    assign tmr_load_s = (state_q == ST_FETCH);
    assign tmr_en_s   = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    assign tmr_long_s = (state_q == ST_STOP);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .STOP_BITS    (STOP_BITS)
    ) u_bit_timer (
        .clk        (clk),
        .rst_n      (reset),
        .clk_enable (clk_enable),
        .load_i     (tmr_load_s),
        .cnt_en_i   (tmr_en_s),
        .long_i     (tmr_long_s),
        .bit_tick_o (tick_s)
    );

    // Frame sequencing, shift register and next output values
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        fifo_read_d  = 1'b0;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        if (load_s) begin
            shift_d = fifo_read_data;
        end else begin
            shift_d = shift_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable && !fifo_empty) begin
                    fifo_read_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                bit_cnt_d = '0;
                state_d   = ST_START;
            end
            ST_START: begin
                if (tick_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_d = {1'b0, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BCW'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (tick_s) begin
                    state_d      = ST_IDLE;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        case (state_d)
            ST_START: tx_d = TX_START;
            ST_DATA:  tx_d = shift_d[0];
            default:  tx_d = TX_IDLE;
        endcase
    end

    // State and output registers; everything holds on disabled cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            tx_q         <= TX_IDLE;
            fifo_read_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            rd_dly_q     <= 1'b0;
        end else if (clk_enable) begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            tx_q         <= tx_d;
            fifo_read_q  <= fifo_read_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            rd_dly_q     <= fifo_read_q;
        end else begin
            state_q      <= state_q;
            shift_q      <= shift_q;
            bit_cnt_q    <= bit_cnt_q;
            tx_q         <= tx_q;
            fifo_read_q  <= fifo_read_q;
            busy_q       <= busy_q;
            frame_done_q <= frame_done_q;
            rd_dly_q     <= rd_dly_q;
        end
    end

    assign tx         = tx_q;
    assign fifo_read  = fifo_read_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a behavioural latency-1 FIFO feeds the DUT, a
// line monitor decodes frames and checks them against a scoreboard queue.
module tb_fifo_uart_tx;
    import fifo_uart_pkg::*;

    localparam int CPB   = 4;
    localparam int DW    = 8;
    localparam int FRAME = int'(frame_cycles(32'd8, 32'd4, 32'd1));

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_enable;
    logic       enable;
    logic       fifo_empty;
    logic       fifo_read;
    logic [7:0] fifo_rdata;
    logic       tx;
    logic       busy;
    logic       frame_done;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         gaps[$];
    int         fd_count = 0;
    int         last_raw_len = 0;

    logic [7:0] mem [0:63];
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    logic       underflow = 1'b0;

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_WIDTH        (DW),
        .CLKS_PER_BIT      (CPB),
        .FIFO_READ_LATENCY (1),
        .STOP_BITS         (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .enable         (enable),
        .fifo_empty     (fifo_empty),
        .fifo_read      (fifo_read),
        .fifo_read_data (fifo_rdata),
        .tx             (tx),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Behavioural FIFO: registered read data, one enabled cycle after the pop
    assign fifo_empty = (wr_cnt == rd_cnt);
    always @(posedge clk) begin
        if (clk_enable && fifo_read) begin
            if (wr_cnt == rd_cnt) begin
                underflow <= 1'b1;
            end else begin
                fifo_rdata <= mem[rd_cnt % 64];
                rd_cnt     <= rd_cnt + 1;
            end
        end
    end

    task automatic push(input logic [7:0] d, input bit expect_tx);
        mem[wr_cnt % 64] = d;
        wr_cnt++;
        if (expect_tx) exp_q.push_back(d);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_fd(input int target, input int budget, input string name);
        int i = 0;
        while (fd_count < target && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk({name, "_frame_done_seen"}, int'(fd_count >= target), 1);
    endtask

    task automatic wait_busy(input int budget, input string name);
        int i = 0;
        while (busy !== 1'b1 && i < budget) begin
            @(posedge clk);
            #1;
            i++;
        end
        chk({name, "_busy_seen"}, int'(busy === 1'b1), 1);
    endtask

    // Line monitor: decodes frames over enabled cycles, compares to scoreboard
    initial begin : mon
        int         pos = 0;
        int         raw = 0;
        int         idle = 0;
        int         bi;
        bit         in_frame = 1'b0;
        bit         pend = 1'b0;
        bit         bad = 1'b0;
        logic [7:0] sh = 8'h00;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                in_frame = 1'b0;
                pend     = 1'b0;
                idle     = 0;
            end else begin
                if (in_frame || pend) raw++;
                if (clk_enable) begin
                    if (pend) begin
                        last_raw_len = raw;
                        pend = 1'b0;
                    end
                    if (frame_done === 1'b1) fd_count++;
                    if (!in_frame) begin
                        if (tx === 1'b0) begin
                            in_frame = 1'b1;
                            pos = 0;
                            raw = 0;
                            bad = 1'b0;
                            sh  = 8'h00;
                            gaps.push_back(idle);
                        end else begin
                            idle++;
                        end
                    end
                    if (in_frame) begin
                        if (pos < CPB) begin
                            if (tx !== 1'b0) bad = 1'b1;
                        end else if (pos < CPB * (DW + 1)) begin
                            bi = (pos - CPB) / CPB;
                            if ((pos - CPB) % CPB == 0) sh[bi] = tx;
                            else if (sh[bi] !== tx) bad = 1'b1;
                        end else begin
                            if (tx !== 1'b1) bad = 1'b1;
                        end
                        pos++;
                        if (pos == FRAME) begin
                            in_frame = 1'b0;
                            pend = 1'b1;
                            idle = 0;
                            chk("frame_expected", int'(exp_q.size() > 0), 1);
                            if (exp_q.size() > 0) begin
                                e = exp_q.pop_front();
                                chk("frame_shape", int'(bad), 0);
                                chk("frame_data", int'(sh), int'(e));
                            end
                        end
                    end
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        int g0;
        int fd_before;
        int i;

        // Reset with data present and enable high: nothing may move
        reset      = 1'b0;
        clk_enable = 1'b1;
        enable     = 1'b1;
        push(8'hA5, 1'b1);
        #40;
        chk("rst_tx", int'(tx), 1);
        chk("rst_fifo_read", int'(fifo_read), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_no_pop", rd_cnt, 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Single word 0xA5
        wait_fd(1, 200, "single");
        chk("single_pops", rd_cnt, 1);
        chk("single_frame_len", last_raw_len, FRAME);
        cycles(5);
        chk("single_fd_count", fd_count, 1);

        // Back-to-back frames with 2-cycle idle gaps
        enable = 1'b0;
        push(8'h00, 1'b1);
        push(8'hFF, 1'b1);
        push(8'h3C, 1'b1);
        g0 = gaps.size();
        enable = 1'b1;
        wait_fd(4, 600, "b2b");
        cycles(20);
        chk("b2b_frames", gaps.size(), g0 + 3);
        chk("b2b_gap1", (gaps.size() > g0 + 1) ? gaps[g0 + 1] : -1, 2);
        chk("b2b_gap2", (gaps.size() > g0 + 2) ? gaps[g0 + 2] : -1, 2);
        chk("b2b_empty", int'(fifo_empty), 1);
        chk("b2b_pops", rd_cnt, 4);

        // Empty FIFO with enable high: no pop
        cycles(100);
        chk("empty_no_pop", rd_cnt, 4);
        chk("empty_not_busy", int'(busy), 0);

        // Enable dropped mid-frame: frame completes, next word stays queued
        enable = 1'b0;
        push(8'h55, 1'b1);
        push(8'h77, 1'b0);
        enable = 1'b1;
        wait_busy(20, "endrop");
        cycles(3);
        enable = 1'b0;
        wait_fd(5, 200, "endrop");
        cycles(30);
        chk("endrop_pops", rd_cnt, 5);
        chk("endrop_word_kept", int'(fifo_empty), 0);

        // Drain the held word
        exp_q.push_back(8'h77);
        enable = 1'b1;
        wait_fd(6, 200, "drain");
        enable = 1'b0;
        chk("drain_pops", rd_cnt, 6);

        // clk_enable toggling every cycle doubles the frame duration
        push(8'h81, 1'b1);
        enable = 1'b1;
        i = 0;
        while (fd_count < 7 && i < 600) begin
            @(posedge clk);
            #1 clk_enable = ~clk_enable;
            i++;
        end
        clk_enable = 1'b1;
        enable = 1'b0;
        chk("ce_frame_done_seen", int'(fd_count >= 7), 1);
        chk("ce_frame_len", last_raw_len, 2 * FRAME);
        cycles(10);
        chk("ce_pops", rd_cnt, 7);
        chk("ce_fd_count", fd_count, 7);

        // Reset in the middle of the data bits of 0x96
        push(8'h96, 1'b0);
        push(8'hC3, 1'b1);
        enable = 1'b1;
        wait_busy(20, "midrst");
        cycles(6);
        chk("midrst_pre_tx", int'(tx), 0);
        fd_before = fd_count;
        #2 reset = 1'b0;
        #1;
        chk("midrst_tx", int'(tx), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_fifo_read", int'(fifo_read), 0);
        cycles(3);
        chk("midrst_no_fd", fd_count, fd_before);
        reset = 1'b1;
        wait_fd(fd_before + 1, 300, "postrst");
        chk("postrst_pops", rd_cnt, 9);
        cycles(5);

        chk("exp_queue_empty", exp_q.size(), 0);
        chk("no_underflow", int'(underflow), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
